serial_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor. It computes Y = A − B − borrow one bit per clock, LSB first, under a start/busy/done handshake. It is the inverse-operation companion to the team's ripple-carry adder and shares its 5-bit result format: difference in Y[WIDTH-1:0], borrow-out in Y[WIDTH]. It sits in the lab arithmetic datapath wherever a small-area, multi-cycle subtract is acceptable.

---
 rtl/sub_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// +-------------------------------------------------------------------+
// | sub_pkg : shared types and constants for serial_subtractor        |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

package sub_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// +-------------------------------------------------------------------+
// | full_subtractor : one-bit combinational subtract cell (a - b - bin)|
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +-------------------------------------------------------------------+
// | serial_subtractor : bit-serial A - B - borrow, LSB first;        |
// | optional signed-overflow output under `SUB_OVF_EN. Revision: 1.0  |
// +-------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Y
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH:0]   y_q, y_d;
  logic             w_d, w_bout;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (w_d),
    .bout (w_bout)
  );

`ifdef SUB_OVF_EN
  // Operand MSBs are kept separately because the shift registers lose them.
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    y_d       = y_q;
`ifdef SUB_OVF_EN
    am_d      = am_q;
    bm_d      = bm_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          a_sr_d    = A;
          b_sr_d    = B;
          br_d      = borrow;
          cnt_d     = '0;
          diff_sr_d = '0;
`ifdef SUB_OVF_EN
          am_d      = A[WIDTH-1];
          bm_d      = B[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        br_d      = w_bout;
        diff_sr_d = {w_d, diff_sr_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = DONE;
          y_d     = {w_bout, w_d, diff_sr_q[WIDTH-1:1]};
`ifdef SUB_OVF_EN
          ovf_d   = (am_q ^ bm_q) & (w_d ^ am_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      cnt_q     <= '0;
      br_q      <= 1'b0;
      y_q       <= '0;
`ifdef SUB_OVF_EN
      am_q      <= 1'b0;
      bm_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      cnt_q     <= cnt_d;
      br_q      <= br_d;
      y_q       <= y_d;
`ifdef SUB_OVF_EN
      am_q      <= am_d;
      bm_q      <= bm_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Y    = y_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +-------------------------------------------------------------------+
// | tb_serial_subtractor : randomized self-checking bench for         |
// | serial_subtractor (WIDTH=4). Revision: 1.0                         |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         borrow = 1'b0;
  logic         busy, done;
  logic [W:0]   Y;
  logic         ovf_obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .borrow (borrow),
    .busy   (busy),
    .done   (done),
    .Y      (Y)
`ifdef SUB_OVF_EN
    ,
    .ovf    (ovf_obs)
`endif
  );

`ifndef SUB_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] ref_y(input int a, input int b, input int bor);
    int r;
    r = a - b - bor;
    return (W+1)'((r + 64) % 32);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bor);
    int r;
    int am, bm, dm;
    r  = (a - b - bor + 64) % 16;
    am = a / 8;
    bm = b / 8;
    dm = r / 8;
    return (am != bm) && (dm != am);
  endfunction

  // Observations of one operation, filled by run_op.
  logic [W:0] o_y;
  logic       o_ovf;
  int         o_busy, o_done, o_done_at, o_overlap;

  task automatic run_op(input int a, input int b, input int bor);
    @(negedge clk);
    A = W'(a); B = W'(b); borrow = bor[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); borrow = 1'($urandom);
    o_busy = 0; o_done = 0; o_done_at = -1; o_overlap = 0;
    o_y = '0; o_ovf = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (busy) o_busy++;
      if (busy && done) o_overlap++;
      if (done) begin
        o_done++;
        if (o_done_at < 0) o_done_at = i;
        o_y = Y; o_ovf = ovf_obs;
      end
      if (i < W + 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Y !== '0 || ovf_obs !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b Y=%b ovf=%b, required 0 0 00000 0", busy, done, Y, ovf_obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int ta[4] = '{9, 3, 0, 8};
    int tb[4] = '{3, 9, 0, 1};
    int tr[4] = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      run_op(ta[k], tb[k], tr[k]);
      checks++;
      if (o_busy !== W || o_done !== 1 || o_done_at !== W || o_overlap !== 0) begin
        failures++;
        $display("FAIL directed_timing[%0d]: busy=%0d done=%0d at=%0d overlap=%0d, required %0d 1 %0d 0",
                 k, o_busy, o_done, o_done_at, o_overlap, W, W);
      end
      checks++;
      if (o_y !== ref_y(ta[k], tb[k], tr[k])) begin
        failures++;
        $display("FAIL directed_Y[%0d]: got %b, required %b", k, o_y, ref_y(ta[k], tb[k], tr[k]));
      end
`ifdef SUB_OVF_EN
      checks++;
      if (o_ovf !== ref_ovf(ta[k], tb[k], tr[k])) begin
        failures++;
        $display("FAIL directed_ovf[%0d]: got %b, required %b", k, o_ovf, ref_ovf(ta[k], tb[k], tr[k]));
      end
`endif
    end
    // The result must hold while idle.
    repeat (3) @(negedge clk);
    checks++;
    if (Y !== ref_y(8, 1, 0)) begin
      failures++;
      $display("FAIL y_hold: got %b, required %b", Y, ref_y(8, 1, 0));
    end
  endtask

  task automatic test_start_ignored_and_back_to_back();
    int dones = 0;
    logic [W:0] y1;
    int a2, b2, r2;
    @(negedge clk);
    A = 4'd9; B = 4'd3; borrow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd1; B = 4'd7; borrow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W + 4 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || Y !== ref_y(9, 3, 0)) begin
      failures++;
      $display("FAIL ignore_start: done=%b Y=%b, required 1 %b", done, Y, ref_y(9, 3, 0));
    end
    y1 = Y;
    // Second request issued in the DONE cycle.
    a2 = int'($urandom_range(0, 15)); b2 = int'($urandom_range(0, 15)); r2 = int'($urandom_range(0, 1));
    A = W'(a2); B = W'(b2); borrow = r2[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || Y !== y1) begin
      failures++;
      $display("FAIL back_to_back_accept: busy=%b done=%b Y=%b, required 1 0 %b", busy, done, Y, y1);
    end
    for (int i = 0; i < W + 2; i++) begin
      if (done) dones++;
      if (done && Y !== ref_y(a2, b2, r2)) begin
        failures++;
        $display("FAIL back_to_back_Y: got %b, required %b", Y, ref_y(a2, b2, r2));
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL back_to_back_done: got %0d pulses, required 1", dones);
    end
  endtask

  task automatic test_held_start();
    int a[3], b[3], r[3];
    int k = 0;
    int cyc = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = int'($urandom_range(0, 15)); b[i] = int'($urandom_range(0, 15)); r[i] = int'($urandom_range(0, 1));
    end
    @(negedge clk);
    A = W'(a[0]); B = W'(b[0]); borrow = r[0][0]; start = 1'b1;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checks++;
        if (Y !== ref_y(a[k], b[k], r[k]) || cyc !== (k + 1) * (W + 1)) begin
          failures++;
          $display("FAIL held_start[%0d]: Y=%b cyc=%0d, required %b %0d", k, Y, cyc, ref_y(a[k], b[k], r[k]), (k + 1) * (W + 1));
        end
        k++;
        if (k < 3) begin A = W'(a[k]); B = W'(b[k]); borrow = r[k][0]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL held_start_count: got %0d results, required 3", k);
    end
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    A = W'($urandom); B = W'($urandom); borrow = 1'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Y !== '0 || ovf_obs !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b Y=%b ovf=%b, required 0 0 00000 0", busy, done, Y, ovf_obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", dones);
    end
  endtask

  task automatic test_exhaustive();
    int errs = 0;
    int order[512];
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int n = 0; n < 512; n++) begin
      int a, b, r;
      a = order[n] % 16; b = (order[n] / 16) % 16; r = order[n] / 256;
      run_op(a, b, r);
      checks++;
      if (o_y !== ref_y(a, b, r) || o_done !== 1 || o_done_at !== W || o_busy !== W
          || o_overlap !== 0 || o_ovf !== (ovf_en() ? ref_ovf(a, b, r) : 1'b0)) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL exhaustive A=%0d B=%0d bor=%0d: Y=%b ovf=%b done=%0d at=%0d busy=%0d, required Y=%b done=1 at=%0d busy=%0d",
                   a, b, r, o_y, o_ovf, o_done, o_done_at, o_busy, ref_y(a, b, r), W, W);
      end
    end
  endtask

  function automatic bit ovf_en();
`ifdef SUB_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_start_ignored_and_back_to_back();
    test_held_start();
    test_reset_mid();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
